// File: rtl/mic1_pkg.sv
// Shared types and constants for the MIC-1 memory sequencer.
// Holds the sequencer state and grant encodings plus the byte-lane selector.
package mic1_pkg;

  localparam int MIC1_AW     = 32;
  localparam int MIC1_DW     = 32;
  localparam int MIC1_LANE_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } mem_state_t;

  typedef enum logic {
    GRANT_DATA  = 1'b0,
    GRANT_FETCH = 1'b1
  } grant_t;

  // Little-endian lane pick: lane 0 is bits 7:0.
  function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                           input logic [MIC1_LANE_W-1:0] lane);
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      2'd3:    return word[31:24];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mic1_rr2.sv
// Two-way round-robin picker between the data and fetch slots.
// Remembers which slot completed last and favours the other one on a tie.
module mic1_rr2
  import mic1_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_data_i,
  input  logic   req_fetch_i,
  input  logic   done_i,
  input  grant_t done_grant_i,
  output grant_t grant_o
);

  grant_t last_q;

  // Record the slot whose transaction just finished.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= GRANT_FETCH;
    end else if (done_i) begin
      last_q <= done_grant_i;
    end else begin
      last_q <= last_q;
    end
  end

  // Single requester wins outright; a tie goes to the slot not served last.
  always_comb begin
    grant_o = GRANT_DATA;
    if (req_data_i && !req_fetch_i) begin
      grant_o = GRANT_DATA;
    end else if (!req_data_i && req_fetch_i) begin
      grant_o = GRANT_FETCH;
    end else if (last_q == GRANT_FETCH) begin
      grant_o = GRANT_DATA;
    end else begin
      grant_o = GRANT_FETCH;
    end
  end

endmodule

// File: rtl/mic1_mem_ctrl.sv
// MIC-1 memory sequencer: shares one single-port memory between the MAR/MDR
// data port and the PC/MBR fetch port, and stalls the core on hazards.
module mic1_mem_ctrl
  import mic1_pkg::*;
#(
  parameter int AW = MIC1_AW,
  parameter int DW = MIC1_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_cmd,
  input  logic          wr_cmd,
  input  logic          fetch_cmd,
  input  logic          use_mdr,
  input  logic          use_mbr,
  input  logic [AW-1:0] mar,
  input  logic [DW-1:0] mdr_q,
  input  logic [AW-1:0] pc,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          mdr_load,
  output logic [DW-1:0] mdr_in,
  output logic          mbr_load,
  output logic [7:0]    mbr_in,
  output logic          stall
);

  mem_state_t    state_q;
  logic          d_pend_q, d_we_q, f_pend_q;
  logic [AW-1:0] d_addr_q, f_addr_q;
  logic [DW-1:0] d_wdata_q;

  logic   in_data, in_fetch, take_data, take_fetch;
  logic   d_pend_d, f_pend_d;
  grant_t grant;

  assign in_data  = (state_q == DATA);
  assign in_fetch = (state_q == FETCH);

  // No completion bypass: a slot pending this cycle stalls even if it acks now.
  assign stall = ((rd_cmd || wr_cmd) && d_pend_q)
              || (fetch_cmd && f_pend_q)
              || (use_mdr && d_pend_q && !d_we_q)
              || (use_mbr && f_pend_q);

  assign take_data  = !stall && (rd_cmd || wr_cmd);
  assign take_fetch = !stall && fetch_cmd;
  assign d_pend_d   = take_data  || (d_pend_q && !(in_data && mem_ack));
  assign f_pend_d   = take_fetch || (f_pend_q && !(in_fetch && mem_ack));

  mic1_rr2 u_rr2 (
    .clk          (clk),
    .rst          (rst),
    .req_data_i   (d_pend_d),
    .req_fetch_i  (f_pend_d),
    .done_i       ((in_data || in_fetch) && mem_ack),
    .done_grant_i (in_data ? GRANT_DATA : GRANT_FETCH),
    .grant_o      (grant)
  );

  // Slot capture and sequencer; IDLE sees this edge's accepts so mem_req rises next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      d_pend_q  <= 1'b0;
      d_we_q    <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      f_pend_q  <= 1'b0;
      f_addr_q  <= '0;
    end else begin
      d_pend_q <= d_pend_d;
      f_pend_q <= f_pend_d;
      if (take_data) begin
        d_we_q   <= wr_cmd;
        d_addr_q <= mar;
        if (wr_cmd) begin
          d_wdata_q <= mdr_q;
        end
      end
      if (take_fetch) begin
        f_addr_q <= pc;
      end
      case (state_q)
        IDLE: begin
          if (d_pend_d || f_pend_d) begin
            state_q <= (grant == GRANT_DATA) ? DATA : FETCH;
          end
        end
        DATA, FETCH: begin
          if (mem_ack) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = in_data || in_fetch;
  assign mem_we    = in_data && d_we_q;
  assign mem_addr  = in_data  ? d_addr_q :
                     in_fetch ? {2'b00, f_addr_q[AW-1:2]} : '0;
  assign mem_wdata = in_data ? d_wdata_q : '0;
  assign mdr_load  = in_data && mem_ack && !d_we_q;
  assign mbr_load  = in_fetch && mem_ack;
  assign mdr_in    = mem_rdata;
  assign mbr_in    = byte_lane(mem_rdata[31:0], f_addr_q[MIC1_LANE_W-1:0]);

endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// Self-checking bench for mic1_mem_ctrl: transaction-level reference model,
// variable-latency memory, directed scenarios then randomized traffic.
module tb_mic1_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rd_cmd, wr_cmd, fetch_cmd, use_mdr, use_mbr;
  logic [31:0] mar, mdr_q, pc;
  logic        mem_req, mem_we, mem_ack, mdr_load, mbr_load, stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, mdr_in;
  logic [7:0]  mbr_in;

  always #5 clk = ~clk;

  mic1_mem_ctrl #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .rd_cmd(rd_cmd), .wr_cmd(wr_cmd), .fetch_cmd(fetch_cmd),
    .use_mdr(use_mdr), .use_mbr(use_mbr), .mar(mar), .mdr_q(mdr_q), .pc(pc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mdr_load(mdr_load), .mdr_in(mdr_in),
    .mbr_load(mbr_load), .mbr_in(mbr_in), .stall(stall)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: two pending slots, which slot owns memory (0 none, 1 data, 2 fetch),
  // and which slot was served last (1 data, 2 fetch).
  bit          m_dp, m_dwe, m_fp;
  logic [31:0] m_daddr, m_dwdata, m_faddr;
  int          m_owner, m_last;
  logic        exp_stall;
  logic [31:0] exp_addr;

  // Memory model.
  logic [31:0] store [logic [31:0]];
  bit          mem_busy, spur_en, force_ack;
  int          mem_rem, lat_fix;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic idle_inputs();
    rd_cmd = 1'b0; wr_cmd = 1'b0; fetch_cmd = 1'b0; use_mdr = 1'b0; use_mbr = 1'b0;
  endtask

  task automatic model_reset();
    m_dp = 1'b0; m_dwe = 1'b0; m_fp = 1'b0;
    m_daddr = 32'd0; m_dwdata = 32'd0; m_faddr = 32'd0;
    m_owner = 0; m_last = 2;
  endtask

  task automatic compare_all();
    logic [31:0] sh;
    logic [31:0] exp_wdata;
    exp_stall = ((rd_cmd | wr_cmd) & m_dp) | (fetch_cmd & m_fp)
              | (use_mdr & m_dp & !m_dwe) | (use_mbr & m_fp);
    exp_addr  = (m_owner == 1) ? m_daddr : (m_owner == 2) ? (m_faddr >> 2) : 32'd0;
    exp_wdata = (m_owner == 1) ? m_dwdata : 32'd0;
    sh = mem_rdata >> (m_faddr[1:0] * 8);
    chk("stall",     {31'd0, stall},    {31'd0, exp_stall});
    chk("mem_req",   {31'd0, mem_req},  {31'd0, m_owner != 0});
    chk("mem_we",    {31'd0, mem_we},   {31'd0, (m_owner == 1) && m_dwe});
    chk("mem_addr",  mem_addr,          exp_addr);
    chk("mem_wdata", mem_wdata,         exp_wdata);
    chk("mdr_load",  {31'd0, mdr_load}, {31'd0, (m_owner == 1) && mem_ack && !m_dwe});
    chk("mbr_load",  {31'd0, mbr_load}, {31'd0, (m_owner == 2) && mem_ack});
    chk("mdr_in",    mdr_in,            mem_rdata);
    chk("mbr_in",    {24'd0, mbr_in},   {24'd0, sh[7:0]});
  endtask

  // Drive memory response for the current cycle, then check every output.
  task automatic cyc_begin();
    #1;
    if (mem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_rem  = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 3);
      end
      mem_ack = (mem_rem == 0);
    end else begin
      mem_busy = 1'b0;
      mem_ack  = force_ack | (spur_en && ($urandom_range(0, 7) == 0));
    end
    if (mem_req && mem_ack && !mem_we)
      mem_rdata = store.exists(mem_addr) ? store[mem_addr] : hash(mem_addr);
    else
      mem_rdata = $urandom();
    #1;
    compare_all();
  endtask

  // Advance the model and memory by one clock using this cycle's inputs.
  task automatic cyc_end();
    bit done_d, done_f, was_idle;
    if (!rst) begin
      model_reset();
    end else begin
      done_d   = (m_owner == 1) && mem_ack;
      done_f   = (m_owner == 2) && mem_ack;
      was_idle = (m_owner == 0);
      if (done_d) begin m_dp = 1'b0; m_last = 1; end
      if (done_f) begin m_fp = 1'b0; m_last = 2; end
      if (!exp_stall) begin
        if (rd_cmd || wr_cmd) begin
          m_dp = 1'b1; m_dwe = wr_cmd; m_daddr = mar;
          if (wr_cmd) m_dwdata = mdr_q;
        end
        if (fetch_cmd) begin m_fp = 1'b1; m_faddr = pc; end
      end
      if (done_d || done_f) m_owner = 0;
      else if (was_idle) begin
        if (m_dp && m_fp) m_owner = (m_last == 2) ? 1 : 2;
        else if (m_dp)    m_owner = 1;
        else if (m_fp)    m_owner = 2;
        else              m_owner = 0;
      end
    end
    if (mem_req && mem_ack && mem_we) store[mem_addr] = mem_wdata;
    if (mem_req && !mem_ack) mem_rem--;
    else if (mem_req) mem_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycle();
    cyc_begin();
    cyc_end();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    rst = 1'b1;
  endtask

  initial begin
    int n;
    bit accepted;
    idle_inputs();
    rst = 1'b0; mar = 32'd0; mdr_q = 32'd0; pc = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    mem_busy = 1'b0; mem_rem = 0; lat_fix = 0; spur_en = 1'b0; force_ack = 1'b0;
    model_reset();
    store[32'h10] = 32'hDEAD_BEEF;
    store[32'h40] = 32'hAABB_CCDD;
    @(negedge clk);
    do_reset(2);

    // Reset state.
    cyc_begin();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall",   {31'd0, stall},   32'd0);
    chk("rst_addr",    mem_addr,         32'd0);
    cyc_end();

    // Zero-wait read, consumer stalls once.
    mar = 32'h10; rd_cmd = 1'b1;
    cyc_begin(); chk("rd_accept_stall", {31'd0, stall}, 32'd0); cyc_end();
    rd_cmd = 1'b0; use_mdr = 1'b1;
    cyc_begin();
    chk("rd_addr",     mem_addr, 32'h10);
    chk("rd_mdr_load", {31'd0, mdr_load}, 32'd1);
    chk("rd_mdr_in",   mdr_in, 32'hDEAD_BEEF);
    chk("rd_use_e1",   {31'd0, stall}, 32'd1);
    chk("model_e1",    {31'd0, exp_stall}, 32'd1);
    cyc_end();
    cyc_begin(); chk("rd_use_e2", {31'd0, stall}, 32'd0); cyc_end();
    use_mdr = 1'b0;

    // Fetch byte lanes.
    pc = 32'h103; fetch_cmd = 1'b1; cycle(); fetch_cmd = 1'b0;
    cyc_begin();
    chk("f_addr",     mem_addr, 32'h40);
    chk("model_addr", exp_addr, 32'h40);
    chk("f_mbr_load", {31'd0, mbr_load}, 32'd1);
    chk("f_lane3",    {24'd0, mbr_in}, 32'hAA);
    cyc_end();
    pc = 32'h100; fetch_cmd = 1'b1; cycle(); fetch_cmd = 1'b0;
    cyc_begin(); chk("f_lane0", {24'd0, mbr_in}, 32'hDD); cyc_end();

    // Simultaneous write + fetch after reset: data first, one idle gap, then fetch.
    do_reset(1);
    mar = 32'h20; mdr_q = 32'h55; pc = 32'h104; wr_cmd = 1'b1; fetch_cmd = 1'b1;
    cycle();
    idle_inputs(); mdr_q = 32'h77;
    cyc_begin();
    chk("arb1_we",    {31'd0, mem_we}, 32'd1);
    chk("arb1_wdata", mem_wdata, 32'h55);
    chk("arb1_addr",  mem_addr, 32'h20);
    cyc_end();
    cyc_begin(); chk("arb1_gap", {31'd0, mem_req}, 32'd0); cyc_end();
    cyc_begin();
    chk("arb1_f_req",  {31'd0, mem_req}, 32'd1);
    chk("arb1_f_addr", mem_addr, 32'h41);
    cyc_end();
    // A lone read leaves data as last served, so the next tie goes to fetch.
    mar = 32'h24; rd_cmd = 1'b1; cycle(); rd_cmd = 1'b0; cycle(); cycle();
    mar = 32'h28; mdr_q = 32'h66; pc = 32'h108; wr_cmd = 1'b1; fetch_cmd = 1'b1;
    cycle();
    idle_inputs();
    cyc_begin();
    chk("arb2_f_first", mem_addr, 32'h42);
    chk("arb2_f_we",    {31'd0, mem_we}, 32'd0);
    cyc_end();
    cycle();
    cyc_begin();
    chk("arb2_d_addr",  mem_addr, 32'h28);
    chk("arb2_d_wdata", mem_wdata, 32'h66);
    cyc_end();
    cycle();

    // Collision with a 3-wait read: the new read stalls until the cycle after ack.
    lat_fix = 3;
    mar = 32'h30; rd_cmd = 1'b1; cycle();
    mar = 32'h34;
    n = 0; accepted = 1'b0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      cyc_begin();
      if (stall) n++; else accepted = 1'b1;
      cyc_end();
    end
    rd_cmd = 1'b0;
    chk("coll_accepted", {31'd0, accepted}, 32'd1);
    chk("coll_stalls",   n, 32'd4);
    for (int i = 0; i < 6; i++) cycle();

    // Read and write together behave as one write.
    lat_fix = 0;
    mar = 32'h38; mdr_q = 32'h99; rd_cmd = 1'b1; wr_cmd = 1'b1; cycle();
    idle_inputs();
    cyc_begin();
    chk("rw_we",       {31'd0, mem_we}, 32'd1);
    chk("rw_wdata",    mem_wdata, 32'h99);
    chk("rw_no_load",  {31'd0, mdr_load}, 32'd0);
    cyc_end();
    cycle();

    // Reset mid-transaction; a late ack must be ignored.
    lat_fix = 5;
    mar = 32'h3C; rd_cmd = 1'b1; cycle(); rd_cmd = 1'b0;
    cycle();
    do_reset(1);
    force_ack = 1'b1; use_mdr = 1'b1; use_mbr = 1'b1;
    cyc_begin();
    chk("mrst_req",   {31'd0, mem_req}, 32'd0);
    chk("mrst_stall", {31'd0, stall}, 32'd0);
    chk("mrst_load",  {31'd0, mdr_load}, 32'd0);
    cyc_end();
    force_ack = 1'b0; idle_inputs();
    cyc_begin(); chk("mrst_after", {31'd0, mem_req}, 32'd0); cyc_end();

    // Randomized traffic against the model.
    lat_fix = -1; spur_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) != 0);
      rd_cmd    = ($urandom_range(0, 3) == 0);
      wr_cmd    = ($urandom_range(0, 5) == 0);
      fetch_cmd = ($urandom_range(0, 2) == 0);
      use_mdr   = ($urandom_range(0, 3) == 0);
      use_mbr   = ($urandom_range(0, 3) == 0);
      mar       = $urandom() & 32'hFF;
      pc        = $urandom() & 32'h3FF;
      mdr_q     = $urandom();
      cycle();
    end
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
